reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Two-requester round-robin arbiter that shares one write port of a small D-flip-flop register bank. Each requester writes through a four-phase req/ack handshake. A registered read port and a completed-write counter are provided for observation. The block sits directly above the flip-flop storage primitives and is the only writer of the bank.

## Interface
- WIDTH, 8, data width of each bank entry
- DEPTH, 4, number of entries; must be a power of 2; AW = $clog2(DEPTH)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  write request, requester 0
- addr0  input  AW  write address, requester 0
- data0  input  WIDTH  write data, requester 0
- ack0  output  1  write-done acknowledge, requester 0 (registered)
- req1 / addr1 / data1 / ack1: identical set for requester 1
- raddr  input  AW  read address
- rdata  output  WIDTH  registered read data, mem[raddr]
- busy  output  1  high when state != IDLE
- wr_cnt  output  8  completed-write count, wraps 255 -> 0

## Operation
- FSM states:
  - IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester named by priority pointer `ptr`. On grant: latch gnt_id, addr, data; go to WR.
  - WR: mem[addr_latched] <= data_latched; ack[gnt_id] <= 1; wr_cnt <= wr_cnt + 1; go to ACK.
  - ACK: hold ack high while req[gnt_id] = 1. When req[gnt_id] = 0 at an edge: ack <= 0, ptr <= ~gnt_id, go to IDLE.
- ptr toggles only after a grant completes, so the last-served requester loses the next tie.
- Requester rules:
  - Hold req, addr and data stable until ack is seen.
  - Drop req after ack.
  - Address and data are sampled only on the IDLE->WR edge. Later changes are ignored.
- A req from the non-granted requester is ignored until the FSM returns to IDLE. It is not lost if held.
- A req that drops before it is granted is never served and leaves no side effect.
- If the granted requester holds req high indefinitely, the FSM stays in ACK. No timeout is provided; the requester protocol forbids this case.
- rdata <= mem[raddr] every cycle, independent of FSM state.

## Timing
- Reset (async, immediate) sets:
  - state = IDLE, ptr = 0 (requester 0 wins first tie)
  - ack0 = ack1 = 0, busy = 0
  - all mem entries = 0, rdata = 0, wr_cnt = 0
- Latency, with req sampled high in IDLE at edge k:
  - edge k: enter WR, busy = 1
  - edge k+1: bank written, ack high, wr_cnt incremented
  - edge k+2: write visible on rdata (when raddr matches)
- Minimum handshake: if req drops in the cycle after ack rises, ACK->IDLE at edge k+2. The next grant is possible at edge k+3, so sustained throughput is 1 write per 3 cycles.
- Simultaneous events:
  - Both reqs rise in the same cycle: resolved by ptr.
  - Read and write to the same address in the same edge: rdata shows the old value, then the new value one cycle later.
- Reset mid-operation:
  - Reset before edge k+1: the WR write does not occur.
  - Reset during ACK: ack drops immediately. The written data is cleared with the rest of mem.
- wr_cnt is 8 bits regardless of WIDTH. It increments once per grant, modulo 256.

## Test plan
- Reset: assert rst mid-cycle with req0 = 1 -> ack0 = 0, busy = 0, rdata = 0 and wr_cnt = 0 immediately. After release, the request is served from IDLE.
- Single write, full handshake: req0 = 1, addr0 = 2, data0 = 8'hA5 at edge k -> ack0 = 1 after edge k+1. Drop req0, then raddr = 2 -> rdata = 8'hA5, wr_cnt = 1.
- Tie resolution: req0 and req1 both high from reset, addr0 = 0/data0 = 8'h11, addr1 = 1/data1 = 8'h22, each requester completing its handshake:
  - requester 0 is acked first, then requester 1
  - mem[0] = 8'h11, mem[1] = 8'h22, wr_cnt = 2
  - ack0 and ack1 never high together
- Fairness under contention: both requesters re-request immediately after each ack, for 6 grants -> grants alternate 0,1,0,1,0,1.
- Ignored changes: change data0 from 8'h3C to 8'hFF one cycle after grant -> the bank holds 8'h3C. A req1 pulse of 1 cycle during ACK0 -> no grant to requester 1, wr_cnt unchanged by it.
- Counter wrap: 256 back-to-back writes from requester 1 -> wr_cnt returns to 0. rdata matches the last data written to each address.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_bank_arbiter: two-requester round-robin arbiter owning the single    |
// | write port of a flip-flop register bank; registered read port.          |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0,
  input  logic [AW-1:0]    i_addr0,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_ack0,
  input  logic             i_req1,
  input  logic [AW-1:0]    i_addr1,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_ack1,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_busy,
  output logic [7:0]       o_wr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_gnt_id;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic             r_ack0;
  logic             r_ack1;
  logic [7:0]       r_wr_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  logic             w_grant;
  logic             w_sel;
  logic             w_gnt_req;
  logic             w_write;
  logic             w_release;

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_sel     = r_ptr;
    w_write   = 1'b0;
    w_release = 1'b0;
    w_gnt_req = r_gnt_id ? i_req1 : i_req0;
    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_grant = 1'b1;
          // A tie goes to the pointer; otherwise the lone requester wins.
          w_sel   = (i_req0 && i_req1) ? r_ptr : i_req1;
          w_next  = S_WR;
        end
      end
      S_WR: begin
        w_write = 1'b1;
        w_next  = S_ACK;
      end
      S_ACK: begin
        if (!w_gnt_req) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= 1'b0;
      r_gnt_id <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_wr_cnt <= 8'd0;
    end else begin
      if (w_grant) begin
        r_gnt_id <= w_sel;
        r_addr   <= w_sel ? i_addr1 : i_addr0;
        r_data   <= w_sel ? i_data1 : i_data0;
      end
      if (w_write) begin
        if (r_gnt_id) r_ack1 <= 1'b1;
        else          r_ack0 <= 1'b1;
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end else if (w_release) begin
        r_ack0 <= 1'b0;
        r_ack1 <= 1'b0;
        // The requester just served loses the next tie.
        r_ptr  <= ~r_gnt_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_write) begin
      r_mem[r_addr] <= r_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_rdata  = r_rdata;
  assign o_busy   = (r_state != S_IDLE);
  assign o_wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_bank_arbiter: directed and randomized bench for reg_bank_arbiter  |
// | against a transaction-level reference model.                            |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_reg_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req  [2];
  logic [AW-1:0]    addr [2];
  logic [WIDTH-1:0] data [2];
  logic [AW-1:0]    raddr;
  logic             ack0, ack1, busy;
  logic [WIDTH-1:0] rdata;
  logic [7:0]       wr_cnt;

  int tests = 0;
  int fails = 0;
  int gq[$];

  always #5 clk = ~clk;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req0  (req[0]),
    .i_addr0 (addr[0]),
    .i_data0 (data[0]),
    .o_ack0  (ack0),
    .i_req1  (req[1]),
    .i_addr1 (addr[1]),
    .i_data1 (data[1]),
    .o_ack1  (ack1),
    .i_raddr (raddr),
    .o_rdata (rdata),
    .o_busy  (busy),
    .o_wr_cnt(wr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic ackv(input int i);
    return (i == 1) ? ack1 : ack0;
  endfunction

  // Reference model: one outstanding grant, written one cycle after grant,
  // released when its owner drops req.
  logic [7:0] m_mem [DEPTH];
  int         m_cnt;
  int         m_owner;
  bit         m_written;
  bit         m_ptr;
  bit         m_ack [2];
  logic [1:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_cnt = 0; m_owner = -1; m_written = 0; m_ptr = 0;
      m_ack[0] = 0; m_ack[1] = 0; m_rdata = 8'h00;
    end else begin
      m_rdata = m_mem[raddr];
      if (m_owner < 0) begin
        if (req[0] || req[1]) begin
          m_owner   = (req[0] && req[1]) ? int'(m_ptr) : (req[1] ? 1 : 0);
          m_addr    = addr[m_owner];
          m_data    = data[m_owner];
          m_written = 0;
        end
      end else if (!m_written) begin
        m_mem[m_addr]  = m_data;
        m_cnt          = (m_cnt + 1) % 256;
        m_ack[m_owner] = 1;
        m_written      = 1;
      end else if (!req[m_owner]) begin
        m_ack[m_owner] = 0;
        m_ptr          = (m_owner == 0);
        m_owner        = -1;
      end
    end
  end

  bit pa0 = 0, pa1 = 0;
  always @(posedge clk) begin
    #1;
    chk("ack0", ack0, m_ack[0]);
    chk("ack1", ack1, m_ack[1]);
    chk("busy", busy, m_owner >= 0);
    chk("rdata", rdata, m_rdata);
    chk("wr_cnt", wr_cnt, m_cnt[7:0]);
    chk("ack_exclusive", ack0 & ack1, 0);
    if (ack0 && !pa0) gq.push_back(0);
    if (ack1 && !pa1) gq.push_back(1);
    pa0 = ack0;
    pa1 = ack1;
  end

  task automatic do_reset();
    rst = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write(input int i, input logic [1:0] a, input logic [7:0] d);
    bit ok;
    ok = 0;
    req[i] = 1'b1; addr[i] = a; data[i] = d;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ackv(i)) ok = 1;
    end
    if (!ok) chk("ack_timeout", 0, 1);
    req[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    raddr = a;
    @(negedge clk);
    chk(name, rdata, exp);
  endtask

  initial begin
    bit ok;
    int done_n;
    logic [7:0] last [DEPTH];
    logic [1:0] a;
    logic [7:0] d;

    rst = 1'b1;
    req[0] = 0; req[1] = 0;
    addr[0] = 0; addr[1] = 0; data[0] = 0; data[1] = 0; raddr = 0;
    repeat (2) @(negedge clk);
    chk("reset_ack0", ack0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_cnt", wr_cnt, 0);
    rst = 1'b0;

    // Asynchronous reset landing mid-cycle during ACK.
    @(negedge clk);
    req[0] = 1; addr[0] = 2'd1; data[0] = 8'h5A;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ack0", ack0, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_wr_cnt", wr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ack0) ok = 1;
    end
    chk("midrst_served", ok, 1);
    chk("midrst_cnt_after", wr_cnt, 1);
    req[0] = 0;
    @(negedge clk);
    read_chk("midrst_rdata_after", 2'd1, 8'h5A);

    // Single write timing.
    do_reset();
    req[0] = 1; addr[0] = 2'd2; data[0] = 8'hA5;
    @(negedge clk);
    chk("single_busy_k", busy, 1);
    chk("single_ack_k", ack0, 0);
    @(negedge clk);
    chk("single_ack_k1", ack0, 1);
    chk("single_cnt_k1", wr_cnt, 1);
    req[0] = 0;
    @(negedge clk);
    chk("single_ack_drop", ack0, 0);
    chk("single_idle", busy, 0);
    read_chk("single_rdata", 2'd2, 8'hA5);

    // Tie from reset.
    rst = 1'b1;
    req[0] = 1; addr[0] = 2'd0; data[0] = 8'h11;
    req[1] = 1; addr[1] = 2'd1; data[1] = 8'h22;
    repeat (2) @(negedge clk);
    gq.delete();
    rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 40 && !(done_n == 2 && !ack0 && !ack1); c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (req[i] && ackv(i)) begin req[i] = 0; done_n++; end
    end
    chk("tie_grants", gq.size(), 2);
    chk("tie_first", (gq.size() > 0) ? gq[0] : 99, 0);
    chk("tie_second", (gq.size() > 1) ? gq[1] : 99, 1);
    chk("tie_wr_cnt", wr_cnt, 2);
    read_chk("tie_mem0", 2'd0, 8'h11);
    read_chk("tie_mem1", 2'd1, 8'h22);

    // Fairness with immediate re-requests.
    do_reset();
    gq.delete();
    req[0] = 1; req[1] = 1;
    for (int c = 0; c < 200 && gq.size() < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ackv(i)) req[i] = 0;
        else if (!req[i] && !ackv(i)) begin
          req[i] = 1; addr[i] = 2'($urandom); data[i] = 8'($urandom);
        end
      end
    end
    chk("fair_count", gq.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      chk("fair_order", (gq.size() > k) ? gq[k] : 99, k % 2);
    req[0] = 0; req[1] = 0;
    repeat (6) @(negedge clk);

    // Late data change and a short req1 pulse during ACK0.
    do_reset();
    gq.delete();
    req[0] = 1; addr[0] = 2'd3; data[0] = 8'h3C;
    @(negedge clk);
    data[0] = 8'hFF;
    @(negedge clk);
    chk("ign_ack0", ack0, 1);
    req[1] = 1; addr[1] = 2'd3; data[1] = 8'h77;
    @(negedge clk);
    req[1] = 0; req[0] = 0;
    repeat (5) @(negedge clk);
    chk("ign_wr_cnt", wr_cnt, 1);
    chk("ign_grants", gq.size(), 1);
    read_chk("ign_mem3", 2'd3, 8'h3C);

    // Counter wrap with requester 1.
    do_reset();
    for (int i = 0; i < DEPTH; i++) last[i] = 8'h00;
    for (int n = 0; n < 256; n++) begin
      a = 2'($urandom);
      d = 8'($urandom);
      write(1, a, d);
      last[a] = d;
    end
    chk("wrap_wr_cnt", wr_cnt, 0);
    for (int i = 0; i < DEPTH; i++) read_chk("wrap_mem", 2'(i), last[i]);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      raddr = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ackv(i)) begin
          if ($urandom_range(0, 1) == 1) req[i] = 0;
          if ($urandom_range(0, 1) == 1) begin
            addr[i] = 2'($urandom); data[i] = 8'($urandom);
          end
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          data[i] = 8'($urandom);
        end else if (!req[i] && !ackv(i) && $urandom_range(0, 2) == 0) begin
          req[i] = 1; addr[i] = 2'($urandom); data[i] = 8'($urandom);
        end
      end
    end
    rst = 0;
    req[0] = 0; req[1] = 0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
